// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the cache memory-side datapath.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BEATS = 2'd1,
    RD_BEATS = 2'd2,
    RESP     = 2'd3
  } mem_adapt_state_t;

  function automatic int unsigned beats_of(input int unsigned line_w,
                                           input int unsigned word_w);
    return line_w / word_w;
  endfunction

  function automatic int unsigned line_off_bits(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int unsigned word_off_bits(input int unsigned word_w);
    return $clog2(word_w / 8);
  endfunction

endpackage

// File: rtl/mem_line_adapter.sv
// Splits whole-line refill/write-back requests into word beats on a narrow
// memory bus and reassembles read beats into a line for the cache controller.
module mem_line_adapter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_mem,
  output logic                  req_ready_mem,
  input  logic                  read_en_mem,
  input  logic                  write_en_mem,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid_mem,
  input  logic                  resp_ready_mem,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [WORD_WIDTH-1:0] mem_cmd_wdata,
  input  logic                  mem_rd_valid,
  input  logic [WORD_WIDTH-1:0] mem_rd_data,
  output logic                  proto_err
);

  localparam int unsigned BEATS = beats_of(LINE_WIDTH, WORD_WIDTH);
  localparam int unsigned IDX_W = $clog2(BEATS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = line_off_bits(LINE_WIDTH);
  localparam int unsigned WSH   = word_off_bits(WORD_WIDTH);
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  mem_adapt_state_t                    state;
  logic [ADDR_WIDTH-1:0]               base_addr;
  logic [BEATS-1:0][WORD_WIDTH-1:0]    line_buf;
  logic [CNT_W-1:0]                    cmd_cnt;
  logic [CNT_W-1:0]                    data_cnt;
  logic                                err_q;

  logic             req_take, accept, both_en, cmd_fire, rd_ok;
  logic [CNT_W-1:0] cmd_seen;

  always_comb begin
    req_ready_mem  = (state == IDLE);
    req_take       = req_valid_mem && req_ready_mem;
    accept         = req_take && (read_en_mem ^ write_en_mem);
    both_en        = req_take && read_en_mem && write_en_mem;
    mem_cmd_valid  = (state == WR_BEATS) || ((state == RD_BEATS) && (cmd_cnt != BEATS_C));
    mem_cmd_we     = (state == WR_BEATS);
    cmd_fire       = mem_cmd_valid && mem_cmd_ready;
    mem_cmd_addr   = base_addr + (ADDR_WIDTH'(cmd_cnt) << WSH);
    mem_cmd_wdata  = line_buf[cmd_cnt[IDX_W-1:0]];
    // A beat may return in the same cycle its command is accepted, so that
    // accept counts toward what is allowed to come back.
    cmd_seen       = cmd_cnt + CNT_W'(cmd_fire && (state == RD_BEATS));
    rd_ok          = mem_rd_valid && (state == RD_BEATS) && (data_cnt < cmd_seen);
    resp_valid_mem = (state == RESP);
    resp_rdata     = line_buf;
    proto_err      = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_addr <= '0;
      line_buf  <= '0;
      cmd_cnt   <= '0;
      data_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((mem_rd_valid && !rd_ok) || both_en) err_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            base_addr             <= req_addr;
            base_addr[OFF_W-1:0]  <= '0;
            line_buf              <= req_wdata;
            cmd_cnt               <= '0;
            data_cnt              <= '0;
            state                 <= write_en_mem ? WR_BEATS : RD_BEATS;
          end
        end
        WR_BEATS: begin
          if (cmd_fire) begin
            cmd_cnt <= cmd_cnt + 1'b1;
            if (cmd_cnt == LAST_C) state <= IDLE;
          end
        end
        RD_BEATS: begin
          if (cmd_fire) cmd_cnt <= cmd_cnt + 1'b1;
          if (rd_ok) begin
            line_buf[data_cnt[IDX_W-1:0]] <= mem_rd_data;
            data_cnt                      <= data_cnt + 1'b1;
            if (data_cnt == LAST_C) state <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_mem) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_adapter.sv
// Directed bench for mem_line_adapter with a small behavioural word memory.
module tb_mem_line_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid_mem, req_ready_mem, read_en_mem, write_en_mem;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid_mem, resp_ready_mem;
  logic [127:0] resp_rdata;
  logic         mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [31:0]  mem_cmd_addr, mem_cmd_wdata;
  logic         mem_rd_valid;
  logic [31:0]  mem_rd_data;
  logic         proto_err;

  always #5 clk = ~clk;

  mem_line_adapter #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid_mem(req_valid_mem), .req_ready_mem(req_ready_mem),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid_mem(resp_valid_mem), .resp_ready_mem(resp_ready_mem),
    .resp_rdata(resp_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: configurable read latency and command backpressure.
  typedef struct { int due; logic [31:0] addr; } pend_t;
  bit          ready_toggle = 1'b0;
  bit          tog = 1'b0;
  bit          stray_req = 1'b0;
  int          rd_lag = 0;
  int          last_rd_cyc = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  pend_t       pend_q[$];
  logic [31:0] mem_a[logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + 32'(a[3:2]) + ({20'd0, a[15:4] - 12'h100} << 8);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_a.exists(a) ? mem_a[a] : mem_word(a);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      mem_rd_valid = 1'b0;
      tog = ~tog;
      mem_cmd_ready = ready_toggle ? tog : 1'b1;
      if (rst) pend_q.delete();
      if (stray_req) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEAD_BEEF;
        stray_req    = 1'b0;
      end else begin
        if (mem_cmd_valid && mem_cmd_ready) begin
          if (mem_cmd_we) begin
            wr_addr_q.push_back(mem_cmd_addr);
            wr_data_q.push_back(mem_cmd_wdata);
            mem_a[mem_cmd_addr] = mem_cmd_wdata;
          end else begin
            rd_addr_q.push_back(mem_cmd_addr);
            if (rd_lag == 0) begin
              mem_rd_valid = 1'b1;
              mem_rd_data  = mem_rd(mem_cmd_addr);
              last_rd_cyc  = cyc;
            end else begin
              pend_q.push_back('{due: cyc + rd_lag, addr: mem_cmd_addr});
            end
          end
        end
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_rd(pend_q[0].addr);
          last_rd_cyc  = cyc;
          void'(pend_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output int lat, output int rcyc, output logic [127:0] line);
    int t0;
    req_addr = addr; read_en_mem = 1'b1; write_en_mem = 1'b0; req_valid_mem = 1'b1;
    t0 = cyc;
    tick();
    req_valid_mem = 1'b0; read_en_mem = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      if (resp_valid_mem) lat = cyc - t0;
      else tick();
    end
    if (lat < 0) chk("read_timeout", resp_valid_mem, 1);
    rcyc = cyc;
    line = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", resp_valid_mem, 1);
      chk("hold_rdata", resp_rdata, line);
      chk("hold_req_ready", req_ready_mem, 0);
      tick();
    end
    resp_ready_mem = 1'b1;
    tick();
    resp_ready_mem = 1'b0;
    chk("resp_drop", resp_valid_mem, 0);
    chk("ready_after_resp", req_ready_mem, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] line,
                          output int lat, output bit saw_resp);
    int t0;
    req_addr = addr; req_wdata = line; write_en_mem = 1'b1; read_en_mem = 1'b0;
    req_valid_mem = 1'b1;
    t0 = cyc;
    tick();
    req_valid_mem = 1'b0; write_en_mem = 1'b0;
    lat = -1; saw_resp = 1'b0;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      if (resp_valid_mem) saw_resp = 1'b1;
      if (req_ready_mem) lat = cyc - t0;
      else tick();
    end
    if (lat < 0) chk("write_timeout", req_ready_mem, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rcyc;
    bit saw;
    logic [127:0] line;
    logic [31:0] exp_d[4];

    req_valid_mem = 0; read_en_mem = 0; write_en_mem = 0; req_addr = '0; req_wdata = '0;
    resp_ready_mem = 0; mem_cmd_ready = 1; mem_rd_valid = 0; mem_rd_data = '0;
    tick(); tick();
    chk("rst_req_ready", req_ready_mem, 1);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    chk("rst_resp_valid", resp_valid_mem, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    rst = 1'b0;
    tick();

    // 1) zero-wait read, data in the command cycle
    rd_addr_q.delete();
    do_read(32'h1000, 0, lat, rcyc, line);
    chk("t1_latency", lat, 5);
    chk("t1_line", line, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t1_ncmds", rd_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++)
      chk("t1_cmd_addr", rd_addr_q[i], 32'h1000 + 32'(4 * i));
    chk("t1_proto_err", proto_err, 0);

    // 2) write-back from an unaligned address
    wr_addr_q.delete(); wr_data_q.delete();
    exp_d = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
    do_write(32'h2004, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, lat, saw);
    chk("t2_ready_latency", lat, 5);
    chk("t2_no_resp", saw, 0);
    chk("t2_nbeats", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      chk("t2_wr_addr", wr_addr_q[i], 32'h2000 + 32'(4 * i));
      chk("t2_wr_data", wr_data_q[i], exp_d[i]);
    end

    // 3) backpressured commands, data lagging three cycles
    rd_lag = 3; ready_toggle = 1'b1;
    do_read(32'h3000, 0, lat, rcyc, line);
    chk("t3_line", line, 128'h000200A3_000200A2_000200A1_000200A0);
    chk("t3_resp_after_last_beat", rcyc, last_rd_cyc + 1);
    rd_lag = 0; ready_toggle = 1'b0;
    tick();

    // 4) response held off for five cycles
    do_read(32'h1000, 5, lat, rcyc, line);
    chk("t4_line", line, 128'h000000A3_000000A2_000000A1_000000A0);

    // 5) stray read data, then both enables at once
    stray_req = 1'b1;
    tick(); tick();
    chk("t5_stray_err", proto_err, 1);
    tick(); tick(); tick();
    chk("t5_err_sticky", proto_err, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_err_cleared", proto_err, 0);
    wr_addr_q.delete(); rd_addr_q.delete();
    req_addr = 32'h5000; read_en_mem = 1'b1; write_en_mem = 1'b1; req_valid_mem = 1'b1;
    tick();
    req_valid_mem = 1'b0; read_en_mem = 1'b0; write_en_mem = 1'b0;
    chk("t5_both_err", proto_err, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_cmd", mem_cmd_valid, 0);
      chk("t5_stay_idle", req_ready_mem, 1);
      tick();
    end
    chk("t5_no_beats", wr_addr_q.size() + rd_addr_q.size(), 0);

    // 6) reset in the middle of a refill
    req_addr = 32'h1000; read_en_mem = 1'b1; req_valid_mem = 1'b1;
    tick();
    req_valid_mem = 1'b0; read_en_mem = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t6_req_ready", req_ready_mem, 1);
    chk("t6_cmd_valid", mem_cmd_valid, 0);
    chk("t6_proto_err", proto_err, 0);
    tick();
    rst = 1'b0;
    rd_addr_q.delete();
    tick(); tick();
    chk("t6_no_more_beats", rd_addr_q.size(), 0);
    chk("t6_idle_resp", resp_valid_mem, 0);

    // back-to-back write-back then refill of the same line
    wr_addr_q.delete();
    do_write(32'h4000, 128'h44444444_33333333_22222222_11111111, lat, saw);
    chk("t6_wb_nbeats", wr_addr_q.size(), 4);
    do_read(32'h4008, 0, lat, rcyc, line);
    chk("t6_refill_latency", lat, 5);
    chk("t6_refill_line", line, 128'h44444444_33333333_22222222_11111111);
    chk("t6_final_err", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
